pipeline_stall_controller: RTL and testbench
============================================

# pipeline_stall_controller

Central stall/flush sequencer for the 5-stage MIPS pipeline. It merges the combinational load-use stall from the hazard detection unit, ID-stage taken-branch flushes, a multi-cycle mul/div occupancy in EX, and data-memory wait states. From these it drives one coherent set of per-stage write-enable and bubble controls. It also keeps a saturating stall-cycle counter for performance measurement.

## Interface
- MD_LATENCY, 32: total cycles a mul/div instruction occupies EX; legal range ≥2.
- CNT_W, 16: width of the stall-cycle counter.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- load_use  in  1  load-use stall request from the hazard detection unit
- branch_taken  in  1  branch/jump resolved taken in ID
- md_start  in  1  EX holds a mul/div instruction; may stay high while that instruction is held
- dmem_wait  in  1  data memory in MEM not ready
- stat_clr  in  1  synchronous clear of stall_count
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  zero IF/ID on this edge
- idex_write  out  1  ID/EX load enable
- idex_bubble  out  1  load NOP controls into ID/EX
- exmem_write  out  1  EX/MEM load enable
- exmem_bubble  out  1  load NOP controls into EX/MEM
- memwb_bubble  out  1  load NOP controls into MEM/WB
- md_busy  out  1  state is MD
- md_done  out  1  one-cycle pulse on the final mul/div cycle
- stall_count  out  CNT_W  cycles with pc_write=0, saturating

## Operation
- State machine:
  - States are RUN and MD.
  - An internal down-counter cnt holds the remaining MD cycles; its width is sized for MD_LATENCY.
- Outputs are combinational from the state, cnt, and the inputs.
- Default (RUN, all requests low):
  - pc_write, ifid_write, idex_write and exmem_write are 1.
  - All flush/bubble outputs, md_busy and md_done are 0.
- Priority, highest first:
  1. **dmem_wait=1 (any state): freeze.**
     - pc_write, ifid_write, idex_write and exmem_write are 0.
     - memwb_bubble=1; all other bubbles and flushes are 0.
     - State and cnt hold; md_start is not accepted.
  2. **RUN with md_start=1: start mul/div.**
     - pc_write, ifid_write and idex_write are 0; exmem_bubble=1.
     - cnt ← MD_LATENCY−2; next state is MD.
  3. **MD with cnt≠0: occupy EX.**
     - Same outputs as the start cycle; cnt decrements; md_start is ignored.
  4. **MD with cnt=0: done cycle.**
     - md_done=1; next state is RUN; md_start is ignored this cycle.
     - Otherwise this cycle uses RUN rules 5–6.
  5. **load_use=1: load-use stall.**
     - pc_write=0, ifid_write=0, idex_bubble=1; EX/MEM advances normally.
  6. **branch_taken=1: branch flush.**
     - ifid_flush=1; pc_write=1.
- load_use and branch_taken high together: load_use wins. The branch stays in ID and is re-evaluated next cycle; no flush this cycle.
- md_busy=1 whenever the state is MD, including the done cycle.
- stall_count:
  - Increments on each edge where pc_write=0.
  - Holds at 2^CNT_W−1 (saturates).
  - stat_clr has priority over increment and loads 0.

## Timing
- Reset values:
  - Asynchronous on rst_n=0: state RUN, cnt 0, stall_count 0.
  - Outputs follow RUN decoding of the current inputs.
- Latency:
  - A mul/div holds EX for exactly MD_LATENCY cycles when dmem_wait stays low.
  - The PC is stalled for MD_LATENCY−1 of those cycles.
  - md_done falls on the MD_LATENCY-th cycle, counted from the md_start cycle.
- Load-use costs exactly 1 cycle; the request is expected to drop once the bubble reaches EX.
- Branch flush costs 1 cycle; there is no stall.
- dmem_wait extends whatever is in progress cycle-for-cycle: cnt does not decrement while it is high.
  - If dmem_wait is high while in MD with cnt=0, md_done is withheld until the first cycle dmem_wait is low.
- rst_n asserted in MD aborts the mul/div immediately; md_busy drops asynchronously.
- MD_LATENCY=2: the state is MD with cnt=0 in the cycle after start, so there is one stall cycle.

## Test plan
- **Idle after reset:** all requests 0 for 5 cycles.
  - Expect pc_write=1, all bubbles 0, stall_count=0.
- **Mul/div, MD_LATENCY=4:** md_start=1 held 4 cycles.
  - Expect pc_write 0,0,0,1; exmem_bubble 1,1,1,0; md_done only in cycle 4; md_busy in cycles 2–4; stall_count=3.
- **dmem_wait during MD, MD_LATENCY=4:** dmem_wait=1 in cycle 2 for 2 cycles.
  - Expect memwb_bubble=1 in those cycles and md_done moved to cycle 6.
- **Load-use with branch:** load_use=1 and branch_taken=1 in one cycle, then branch_taken only.
  - Expect cycle 1: idex_bubble=1, ifid_flush=0, pc_write=0.
  - Expect cycle 2: ifid_flush=1, pc_write=1.
- **Counter saturation and clear, CNT_W=4:** load_use held 20 cycles, then stat_clr=1 together with load_use=1.
  - Expect stall_count saturated at 15, then 0 after the clear (clear beats increment).
- **Reset mid-operation:** rst_n pulsed low in MD (cnt=10).
  - Expect md_busy=0 immediately; after release, the default RUN outputs.

Source files
------------

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: merges load-use, branch flush,
// multi-cycle mul/div occupancy and dmem wait states into per-stage enables.
module pipeline_stall_controller #(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use,
  input  logic             branch_taken,
  input  logic             md_start,
  input  logic             dmem_wait,
  input  logic             stat_clr,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic             exmem_write,
  output logic             exmem_bubble,
  output logic             memwb_bubble,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_count
);

  // state | meaning
  // Run   | normal flow; load-use / branch rules apply
  // Md    | mul/div occupies EX; cnt = remaining cycles before the done cycle
  typedef enum logic {Run, Md} stateT;

  localparam int                MdCntW   = $clog2(MD_LATENCY);
  localparam logic [MdCntW-1:0] MdLoad   = MdCntW'(MD_LATENCY - 2);
  localparam logic [CNT_W-1:0]  CountMax = '1;

  stateT             state, stateNext;
  logic [MdCntW-1:0] cnt, cntNext;
  logic [CNT_W-1:0]  countNext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= Run;
      cnt         <= '0;
      stall_count <= '0;
    end else begin
      state       <= stateNext;
      cnt         <= cntNext;
      stall_count <= countNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    if (!dmem_wait) begin
      if (state == Run) begin
        if (md_start) begin
          stateNext = Md;
          cntNext   = MdLoad;
        end
      end else if (cnt != '0) begin
        cntNext = cnt - MdCntW'(1);
      end else begin
        stateNext = Run;
      end
    end
  end

  // Saturating stall counter; clear wins over increment.
  always_comb begin
    countNext = stall_count;
    if (stat_clr)
      countNext = '0;
    else if (!pc_write && stall_count != CountMax)
      countNext = stall_count + CNT_W'(1);
  end

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_bubble  = 1'b0;
    exmem_write  = 1'b1;
    exmem_bubble = 1'b0;
    memwb_bubble = 1'b0;
    md_busy      = (state == Md);
    md_done      = 1'b0;
    if (dmem_wait) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      memwb_bubble = 1'b1;
    end else if ((state == Run && md_start) || (state == Md && cnt != '0)) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_bubble = 1'b1;
    end else begin
      md_done = (state == Md);
      // load_use beats branch: the branch stays in ID and re-resolves next cycle
      if (load_use) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end else if (branch_taken) begin
        ifid_flush = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench: directed literal sequences plus randomized stimulus
// compared every cycle against a remaining-cycles behavioural model.
module tb_pipeline_stall_controller;
  localparam int LAT  = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_use = 1'b0, branch_taken = 1'b0, md_start = 1'b0, dmem_wait = 1'b0, stat_clr = 1'b0;
  logic pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
  logic exmem_write, exmem_bubble, memwb_bubble, md_busy, md_done;
  logic [CW-1:0] stall_count;

  pipeline_stall_controller #(.MD_LATENCY(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .load_use(load_use), .branch_taken(branch_taken),
    .md_start(md_start), .dmem_wait(dmem_wait), .stat_clr(stat_clr),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_write(idex_write), .idex_bubble(idex_bubble), .exmem_write(exmem_write),
    .exmem_bubble(exmem_bubble), .memwb_bubble(memwb_bubble), .md_busy(md_busy),
    .md_done(md_done), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int mdLeft = 0;    // cycles of the current mul/div still to come, including this one
  int modelCount = 0;

  // {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
  //  exmem_write, exmem_bubble, memwb_bubble, md_busy, md_done}
  function automatic logic [9:0] expCtrl();
    logic pw, iw, fl, xw, xb, ew, eb, mb, busy, done;
    pw = 1; iw = 1; fl = 0; xw = 1; xb = 0; ew = 1; eb = 0; mb = 0; done = 0;
    busy = (mdLeft > 0);
    if (dmem_wait) begin
      pw = 0; iw = 0; xw = 0; ew = 0; mb = 1;
    end else if ((mdLeft == 0 && md_start) || mdLeft > 1) begin
      pw = 0; iw = 0; xw = 0; eb = 1;
    end else begin
      done = (mdLeft == 1);
      if (load_use) begin
        pw = 0; iw = 0; xb = 1;
      end else if (branch_taken) begin
        fl = 1;
      end
    end
    return {pw, iw, fl, xw, xb, ew, eb, mb, busy, done};
  endfunction

  function automatic logic [9:0] actCtrl();
    return {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
            exmem_write, exmem_bubble, memwb_bubble, md_busy, md_done};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic checkModel();
    check("ctrl", int'(actCtrl()), int'(expCtrl()));
    check("stall_count", int'(stall_count), modelCount);
  endtask

  task automatic modelEdge();
    logic [9:0] e;
    e = expCtrl();
    if (stat_clr) modelCount = 0;
    else if (!e[9] && modelCount < CMAX) modelCount++;
    if (!dmem_wait) begin
      if (mdLeft > 0) mdLeft--;
      else if (md_start) mdLeft = LAT - 1;
    end
  endtask

  task automatic modelReset();
    mdLeft = 0;
    modelCount = 0;
  endtask

  // One clock: drive inputs, check at negedge (plus optional literals), advance model at posedge.
  task automatic cycle(input logic lu, input logic bt, input logic ms, input logic dw,
                       input logic clr, input int ePw, input int eDone);
    load_use = lu; branch_taken = bt; md_start = ms; dmem_wait = dw; stat_clr = clr;
    @(negedge clk);
    checkModel();
    if (ePw >= 0) check("pc_write literal", int'(pc_write), ePw);
    if (eDone >= 0) check("md_done literal", int'(md_done), eDone);
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  initial begin
    int p;
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, 1, 0);
    check("idle count", int'(stall_count), 0);

    p = 1;
    for (int i = 1; i <= 4; i++) cycle(0, 0, 1, 0, 0, (i == 4) ? 1 : 0, (i == 4) ? 1 : 0);
    check("md count", int'(stall_count), 3);
    cycle(0, 0, 0, 0, 1, 1, 0);
    check("clear", int'(stall_count), 0);

    for (int i = 1; i <= 6; i++)
      cycle(0, 0, 1, (i == 2 || i == 3), 0, (i == 6) ? 1 : 0, (i == 6) ? 1 : 0);
    cycle(0, 0, 0, 0, 0, 1, 0);

    cycle(1, 1, 0, 0, 0, 0, 0);
    check("lu flush literal", int'(ifid_flush), 0);
    cycle(0, 1, 0, 0, 0, 1, 0);

    cycle(0, 0, 0, 0, 1, -1, -1);
    for (int i = 0; i < 20; i++) cycle(1, 0, 0, 0, 0, 0, 0);
    check("saturated", int'(stall_count), 15);
    cycle(1, 0, 0, 0, 1, 0, 0);
    check("clear beats inc", int'(stall_count), 0);

    cycle(0, 0, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    load_use = 0; branch_taken = 0; md_start = 0; dmem_wait = 0; stat_clr = 0;
    #1 rst_n = 1'b0;
    #1;
    modelReset();
    check("reset md_busy", int'(md_busy), 0);
    check("reset pc_write", int'(pc_write), 1);
    checkModel();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle(0, 0, 0, 0, 0, 1, 0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        #2;
        modelReset();
        checkModel();
        rst_n = 1'b1;
      end
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 40) == 0, -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
